la_axis_arbiter: RTL and testbench
==================================

# la_axis_arbiter

Packet-locked two-source AXI-Stream arbiter that shares the single upstream AXIS egress port between the logic-analyzer trace stream and the user-project stream. Sits between the LA trace FIFO output and the AXIS switch. It honours the LA high-priority request, bounds unterminated bursts, and prevents starvation of the user stream.

## Interface
- DATA_WIDTH, 32: tdata width; tstrb/tkeep are DATA_WIDTH/8.
- MAX_BURST, 16: maximum beats per grant; the arbiter forces tlast on the last one.
- STARVE_LIMIT, 4: maximum consecutive priority-forced LA grants while the user stream waits.
- axis_clk  in  1  the single clock.
- axis_rst  in  1  asynchronous, active-high reset.
- s0_tdata/s0_tstrb/s0_tkeep/s0_tlast/s0_tuser[1:0]/s0_tvalid  in  —  LA trace stream.
- s0_tready  out  1  ready to the LA stream.
- s1_tdata/s1_tstrb/s1_tkeep/s1_tlast/s1_tuser[1:0]/s1_tvalid  in  —  user-project stream.
- s1_tready  out  1  ready to the user stream.
- la_hpri_req  in  1  LA FIFO above its high threshold.
- m_tdata/m_tstrb/m_tkeep/m_tlast/m_tuser/m_tvalid  out  —  egress stream.
- m_tready  in  1  egress ready.
- grant_id  out  2  current grant: 00 none, 01 LA, 10 user.

## Operation
- FSM states and transitions:
  - IDLE: no grant. On any sX_tvalid, register a winner and move to GNT_LA or GNT_USR.
  - GNT_LA / GNT_USR: mux the granted source to m_*. sX_tready = m_tready for the granted source; 0 for the other.
- Winner selection in IDLE, first matching rule applies:
  1. Only one source valid: that source wins.
  2. Both valid, la_hpri_req=1, starve_cnt<STARVE_LIMIT: LA wins; starve_cnt increments.
  3. Both valid, la_hpri_req=1, starve_cnt==STARVE_LIMIT: user wins; starve_cnt clears.
  4. Both valid, la_hpri_req=0: round-robin against last_grant (the source not served last wins).
- starve_cnt clears on any user grant. It also clears when LA wins while s1_tvalid=0.
- last_grant updates on every grant.
- beat_cnt, width $clog2(MAX_BURST+1), clears on grant and increments on each accepted beat (m_tvalid&m_tready).
- Release condition: an accepted beat with source tlast=1, or beat_cnt==MAX_BURST-1. Release returns the FSM to IDLE.
- m_tlast = src_tlast | (beat_cnt==MAX_BURST-1), so the forced boundary is visible downstream.
- The arbiter never drops, duplicates, or reorders beats. tuser/tstrb/tkeep pass through unmodified.

## Timing
- Reset values: FSM=IDLE, grant_id=00, m_tvalid=0, m_tlast=0, m_tdata/m_tstrb/m_tkeep/m_tuser=0, s0_tready=0, s1_tready=0, beat_cnt=0, starve_cnt=0, last_grant=user (so LA wins the first tie).
- Grant latency: 1 cycle from sX_tvalid in IDLE to m_tvalid. There is one bubble cycle in IDLE between packets.
- Data path is combinational in the GNT states (zero-latency pass-through). Only the grant is registered.
- Holding rule: once granted, the grant holds even if the source deasserts tvalid mid-packet. This holds until release or reset.
- la_hpri_req is sampled only in IDLE. Assertion mid-packet never preempts.
- Simultaneous tlast on the granted source and the MAX_BURST limit on the same beat: a single release; m_tlast=1 once.
- Stall: with m_tready=0, m_* stays stable and the grant holds indefinitely.
- Reset mid-packet: outputs return to reset values asynchronously. The in-flight packet is truncated without tlast, and sources must re-send.

## Structure
- Shared package la_pkg: grant_id encodings (GNT_NONE/GNT_LA/GNT_USR), FSM state enum, default MAX_BURST/STARVE_LIMIT constants.
- Natural sub-module: la_rr_pick. It is the combinational winner-select implementing the four IDLE rules, from (s0_tvalid, s1_tvalid, la_hpri_req, starve_cnt, last_grant).
- Counters and the FSM live in the top.

## Test plan
- Reset, then s0 packet of 3 beats (tlast on beat 3), m_tready=1. Expect: m_tvalid rises 1 cycle after s0_tvalid; 3 beats out; grant_id 01→00.
- Both valid, la_hpri_req=0, four 2-beat packets each. Expect: grants alternate LA,USR,LA,USR, with one bubble between packets.
- Both continuously valid, la_hpri_req=1, STARVE_LIMIT=4. Expect: grant order LA,LA,LA,LA,USR, then repeating.
- s1 sends 20 beats with no tlast, MAX_BURST=16. Expect: m_tlast=1 on beat 16, FSM to IDLE, then the remaining 4 beats on a new grant.
- m_tready toggled 1010… during an LA packet. Expect: m_tdata stable while stalled, no beat lost; s1_tready=0 throughout.
- axis_rst pulsed on beat 2 of a 5-beat packet. Expect: m_tvalid=0 and grant_id=00 the same cycle; the next grant follows normal selection.

Source files
------------

// File: rtl/la_pkg.sv
// la_pkg: shared grant encodings, FSM states and default sizing for la_axis_arbiter
package la_pkg;
  typedef enum logic [1:0] {GNT_NONE = 2'b00, GNT_LA = 2'b01, GNT_USR = 2'b10} grant_t;
  typedef enum logic [1:0] {S_IDLE, S_GNT_LA, S_GNT_USR} state_t;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_MAX_BURST    = 16;
  localparam int DEF_STARVE_LIMIT = 4;
endpackage

// File: rtl/la_rr_pick.sv
// la_rr_pick: combinational winner select between LA and user streams while idle
module la_rr_pick
  import la_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int SW           = $clog2(STARVE_LIMIT + 1)
) (
  input  logic          i_s0_valid,
  input  logic          i_s1_valid,
  input  logic          i_hpri,
  input  logic [SW-1:0] i_starve_cnt,
  input  grant_t        i_last_grant,
  output logic          o_valid,
  output logic          o_usr,
  output logic          o_force
);
  logic w_both;
  logic w_starved;
  assign w_both    = i_s0_valid & i_s1_valid;
  assign w_starved = i_starve_cnt >= SW'(STARVE_LIMIT);
  assign o_valid   = i_s0_valid | i_s1_valid;
  // a tie without priority goes to whichever source was not served last
  assign o_usr     = !w_both ? i_s1_valid : i_hpri ? w_starved : (i_last_grant == GNT_LA);
  assign o_force   = w_both & i_hpri & !w_starved;
endmodule

// File: rtl/la_axis_arbiter.sv
// la_axis_arbiter: packet-locked two-source AXIS arbiter (LA trace vs user stream)
// with LA priority, burst bounding and user-stream anti-starvation.
module la_axis_arbiter
  import la_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int MAX_BURST    = DEF_MAX_BURST,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                    axis_clk,
  input  logic                    axis_rst,
  input  logic [DATA_WIDTH-1:0]   s0_tdata,
  input  logic [DATA_WIDTH/8-1:0] s0_tstrb,
  input  logic [DATA_WIDTH/8-1:0] s0_tkeep,
  input  logic                    s0_tlast,
  input  logic [1:0]              s0_tuser,
  input  logic                    s0_tvalid,
  output logic                    s0_tready,
  input  logic [DATA_WIDTH-1:0]   s1_tdata,
  input  logic [DATA_WIDTH/8-1:0] s1_tstrb,
  input  logic [DATA_WIDTH/8-1:0] s1_tkeep,
  input  logic                    s1_tlast,
  input  logic [1:0]              s1_tuser,
  input  logic                    s1_tvalid,
  output logic                    s1_tready,
  input  logic                    la_hpri_req,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tstrb,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic                    m_tlast,
  output logic [1:0]              m_tuser,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [1:0]              grant_id
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  state_t        r_state;
  grant_t        r_grant_id;
  grant_t        r_last_grant;
  logic [BW-1:0] r_beat_cnt;
  logic [SW-1:0] r_starve_cnt;
  logic          w_la;
  logic          w_usr;
  logic          w_src_last;
  logic          w_limit;
  logic          w_fire;
  logic          w_pick_valid;
  logic          w_pick_usr;
  logic          w_pick_force;
  assign w_la       = r_state == S_GNT_LA;
  assign w_usr      = r_state == S_GNT_USR;
  // pure combinational pass-through; everything reads as zero while idle
  assign m_tdata    = w_la ? s0_tdata  : w_usr ? s1_tdata  : '0;
  assign m_tstrb    = w_la ? s0_tstrb  : w_usr ? s1_tstrb  : '0;
  assign m_tkeep    = w_la ? s0_tkeep  : w_usr ? s1_tkeep  : '0;
  assign m_tuser    = w_la ? s0_tuser  : w_usr ? s1_tuser  : '0;
  assign m_tvalid   = w_la ? s0_tvalid : w_usr ? s1_tvalid : 1'b0;
  assign w_src_last = w_la ? s0_tlast  : w_usr ? s1_tlast  : 1'b0;
  assign w_limit    = r_beat_cnt == BW'(MAX_BURST - 1);
  assign m_tlast    = (w_la | w_usr) & (w_src_last | w_limit);
  assign s0_tready  = w_la & m_tready;
  assign s1_tready  = w_usr & m_tready;
  assign w_fire     = m_tvalid & m_tready;
  assign grant_id   = r_grant_id;
  la_rr_pick #(.STARVE_LIMIT(STARVE_LIMIT), .SW(SW)) u_pick (
    .i_s0_valid   (s0_tvalid),
    .i_s1_valid   (s1_tvalid),
    .i_hpri       (la_hpri_req),
    .i_starve_cnt (r_starve_cnt),
    .i_last_grant (r_last_grant),
    .o_valid      (w_pick_valid),
    .o_usr        (w_pick_usr),
    .o_force      (w_pick_force)
  );
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_state      <= S_IDLE;
      r_grant_id   <= GNT_NONE;
      r_last_grant <= GNT_USR;
      r_beat_cnt   <= '0;
      r_starve_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_pick_valid) begin
        r_state      <= w_pick_usr ? S_GNT_USR : S_GNT_LA;
        r_grant_id   <= w_pick_usr ? GNT_USR : GNT_LA;
        r_last_grant <= w_pick_usr ? GNT_USR : GNT_LA;
        r_beat_cnt   <= '0;
        r_starve_cnt <= w_pick_force ? r_starve_cnt + SW'(1) : (w_pick_usr || !s1_tvalid) ? '0 : r_starve_cnt;
      end
    end else if (w_fire) begin
      r_beat_cnt <= r_beat_cnt + BW'(1);
      if (w_src_last || w_limit) begin
        r_state    <= S_IDLE;
        r_grant_id <= GNT_NONE;
      end
    end
  end
endmodule

// File: tb/tb_la_axis_arbiter.sv
// tb_la_axis_arbiter: directed self-checking bench for la_axis_arbiter
module tb_la_axis_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s0_tdata, s1_tdata, m_tdata;
  logic [3:0]  s0_tstrb, s0_tkeep, s1_tstrb, s1_tkeep, m_tstrb, m_tkeep;
  logic [1:0]  s0_tuser, s1_tuser, m_tuser, grant_id;
  logic        s0_tlast, s0_tvalid, s0_tready, s1_tlast, s1_tvalid, s1_tready;
  logic        la_hpri_req, m_tlast, m_tvalid, m_tready;
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] q_data[$];
  logic        q_last[$];
  logic [1:0]  q_gnt[$];
  logic [1:0]  q_user[$];
  logic [3:0]  q_keep[$];
  int          q_cyc[$];

  la_axis_arbiter #(.DATA_WIDTH(32), .MAX_BURST(16), .STARVE_LIMIT(4)) dut (
    .axis_clk(clk), .axis_rst(rst),
    .s0_tdata(s0_tdata), .s0_tstrb(s0_tstrb), .s0_tkeep(s0_tkeep), .s0_tlast(s0_tlast),
    .s0_tuser(s0_tuser), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tstrb(s1_tstrb), .s1_tkeep(s1_tkeep), .s1_tlast(s1_tlast),
    .s1_tuser(s1_tuser), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
    .la_hpri_req(la_hpri_req),
    .m_tdata(m_tdata), .m_tstrb(m_tstrb), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tuser(m_tuser), .m_tvalid(m_tvalid), .m_tready(m_tready), .grant_id(grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      q_data.push_back(m_tdata);
      q_last.push_back(m_tlast);
      q_gnt.push_back(grant_id);
      q_user.push_back(m_tuser);
      q_keep.push_back(m_tkeep);
      q_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    q_data.delete(); q_last.delete(); q_gnt.delete();
    q_user.delete(); q_keep.delete(); q_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s0_tvalid = 1'b0; s1_tvalid = 1'b0; s0_tlast = 1'b0; s1_tlast = 1'b0;
    la_hpri_req = 1'b0; m_tready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_q();
  endtask

  task automatic chk_beat(input string tag, input int i, input logic [31:0] d, input logic l, input logic [1:0] g);
    if (i >= q_data.size()) chk({tag, "_count"}, q_data.size(), i + 1);
    else begin
      chk({tag, "_data"}, q_data[i], d);
      chk({tag, "_last"}, q_last[i], l);
      chk({tag, "_gnt"}, q_gnt[i], g);
      chk({tag, "_user"}, q_user[i], g);
      chk({tag, "_keep"}, q_keep[i], g == 2'b01 ? 4'hF : 4'h3);
    end
  endtask

  task automatic send(input int src, input int n, input logic [31:0] base, input bit last);
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      if (src == 0) begin s0_tvalid = 1'b1; s0_tdata = base + i; s0_tlast = last && (i == n - 1); end
      else begin s1_tvalid = 1'b1; s1_tdata = base + i; s1_tlast = last && (i == n - 1); end
      do begin @(negedge clk); t++; end while (!(src == 0 ? s0_tready : s1_tready) && t < 200);
      if (t >= 200) chk($sformatf("send%0d_ready", src), src == 0 ? s0_tready : s1_tready, 1);
      @(posedge clk); #1;
    end
    if (src == 0) begin s0_tvalid = 1'b0; s0_tlast = 1'b0; end
    else begin s1_tvalid = 1'b0; s1_tlast = 1'b0; end
  endtask

  initial begin
    logic [1:0] exp_g3 [10] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    logic [31:0] exp_d2 [8] = '{32'hA0, 32'hA1, 32'hB0, 32'hB1, 32'hA2, 32'hA3, 32'hB2, 32'hB3};
    int k;
    s0_tuser = 2'b01; s0_tkeep = 4'hF; s0_tstrb = 4'hF;
    s1_tuser = 2'b10; s1_tkeep = 4'h3; s1_tstrb = 4'h3;
    s0_tdata = 32'hFFFF_FFFF; s0_tvalid = 1'b1; s0_tlast = 1'b1;
    s1_tdata = 32'h0; s1_tvalid = 1'b0; s1_tlast = 1'b0;
    la_hpri_req = 1'b0; m_tready = 1'b1;
    // reset values while a source is presenting
    @(negedge clk);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_s0_tready", s0_tready, 0);
    chk("rst_s1_tready", s1_tready, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tuser", m_tuser, 0);
    do_reset();
    // single 3-beat LA packet and grant latency
    fork
      send(0, 3, 32'h100, 1'b1);
      begin
        @(negedge clk); chk("t1_lat0", m_tvalid, 0);
        @(negedge clk); chk("t1_lat1", m_tvalid, 1); chk("t1_gnt", grant_id, 1);
      end
    join
    @(negedge clk); chk("t1_release", grant_id, 0);
    for (int i = 0; i < 3; i++) chk_beat("t1", i, 32'h100 + i, i == 2, 2'd1);
    chk("t1_n", q_data.size(), 3);
    // round robin without priority
    do_reset();
    fork
      begin send(0, 2, 32'hA0, 1'b1); send(0, 2, 32'hA2, 1'b1); end
      begin send(1, 2, 32'hB0, 1'b1); send(1, 2, 32'hB2, 1'b1); end
    join
    for (int i = 0; i < 8; i++) chk_beat("t2", i, exp_d2[i], i % 2 == 1, (i / 2) % 2 == 0 ? 2'd1 : 2'd2);
    if (q_cyc.size() > 2) chk("t2_bubble", q_cyc[2] - q_cyc[1], 2);
    // priority with anti-starvation
    do_reset();
    la_hpri_req = 1'b1;
    fork
      for (int p = 0; p < 8; p++) send(0, 1, 32'h300 + p, 1'b1);
      for (int p = 0; p < 2; p++) send(1, 1, 32'h3B0 + p, 1'b1);
    join
    la_hpri_req = 1'b0;
    for (int i = 0; i < 10; i++)
      if (i < q_gnt.size()) chk($sformatf("t3_gnt%0d", i), q_gnt[i], exp_g3[i]);
      else chk("t3_count", q_gnt.size(), i + 1);
    // unterminated 20-beat user burst is cut at 16
    do_reset();
    send(1, 20, 32'h200, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 20; i++) chk_beat($sformatf("t4_b%0d", i), i, 32'h200 + i, i == 15, 2'd2);
    if (q_cyc.size() > 16) chk("t4_bubble", q_cyc[16] - q_cyc[15], 2);
    chk("t4_hold_gnt", grant_id, 2);
    chk("t4_hold_ready", s1_tready, 1);
    chk("t4_hold_s0", s0_tready, 0);
    chk("t4_hold_tvalid", m_tvalid, 0);
    // backpressure on an LA packet while the user waits
    do_reset();
    s1_tvalid = 1'b1; s1_tdata = 32'h5F0; s1_tlast = 1'b1;
    k = 0;
    fork
      send(0, 4, 32'h500, 1'b1);
      for (int i = 0; i < 12; i++) begin
        m_tready = (i % 2 == 0);
        @(negedge clk);
        if (grant_id == 2'd1) begin
          chk("t5_s1_tready", s1_tready, 0);
          chk("t5_data", m_tdata, 32'h500 + k);
          if (m_tready && m_tvalid) k++;
        end
        @(posedge clk); #1;
      end
    join
    s1_tvalid = 1'b0; m_tready = 1'b1;
    chk("t5_beats", k, 4);
    for (int i = 0; i < 4; i++) chk_beat("t5", i, 32'h500 + i, i == 3, 2'd1);
    // asynchronous reset on beat 2 of a packet
    do_reset();
    s0_tvalid = 1'b1; s0_tdata = 32'h600; s0_tlast = 1'b0;
    s1_tvalid = 1'b1; s1_tdata = 32'h6F0; s1_tlast = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    s0_tdata = 32'h601;
    #2 rst = 1'b1;
    #1;
    chk("t6_tvalid", m_tvalid, 0);
    chk("t6_gnt", grant_id, 0);
    chk("t6_s0_tready", s0_tready, 0);
    chk("t6_tdata", m_tdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); chk("t6_idle", m_tvalid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_regrant", grant_id, 1);
    chk("t6_redata", m_tdata, 32'h601);
    chk("t6_s1_wait", s1_tready, 0);
    s0_tvalid = 1'b0; s1_tvalid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
